// File: rtl/ram_pkg.sv
// ram_pkg: shared types, constants and helpers for the ram_2p dual-port RAM.
//   ram_state_e    control FSM state encoding
//   ram_idx_t      decoded word index plus in-range flag
//   ram_word_idx   byte address -> word index / range check
//   RAM_MAX_RD_LAT upper bound of the response latency parameter
//   RAM_BE_W       number of byte lanes for a given word width
package ram_pkg;

  localparam int unsigned RAM_MAX_RD_LAT = 4;

  typedef enum logic [1:0] {
    RAM_ST_RESET = 2'd0,
    RAM_ST_CLEAR = 2'd1,
    RAM_ST_READY = 2'd2
  } ram_state_e;

  typedef struct packed {
    logic        in_range;
    logic [31:0] idx;
  } ram_idx_t;

  // Byte lanes per word.
  function automatic int unsigned RAM_BE_W(input int unsigned data_w);
    return data_w / 32'd8;
  endfunction

  // Word index relative to base; the offset inside the word is dropped. The
  // range test is done on the word index so base + size never has to be
  // formed (it may not fit in 32 bits).
  function automatic ram_idx_t ram_word_idx(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned shift,
                                            input int unsigned depth);
    ram_idx_t    r;
    logic [31:0] off;
    off        = addr - base;
    r.idx      = off >> shift;
    r.in_range = (addr >= base) && (r.idx < depth);
    return r;
  endfunction

endpackage

// File: rtl/ram_rsp_pipe.sv
// ram_rsp_pipe: RD_LAT-deep shift pipeline of {valid, err, rdata} for one
// RAM port. Stage 0 captures the response on the acceptance edge, the last
// stage drives the port outputs. Reset clears every stage asynchronously so
// in-flight responses vanish the moment reset is asserted.
//   clk_i, rst_ni        clock, async active-low reset
//   valid_i/err_i/rdata_i response formed in the acceptance cycle
//   rvalid_o/err_o/rdata_o delayed response
module ram_rsp_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              rvalid_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] err_q;
  logic [DATA_W-1:0] data_q [RD_LAT];

  // Response shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= err_i;
      data_q[0]  <= rdata_i;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign rvalid_o = valid_q[RD_LAT-1];
  assign err_o    = err_q[RD_LAT-1];
  assign rdata_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/ram_2p.sv
// ram_2p: true dual-port RAM with byte enables, req/gnt handshake,
// same-word write collision stalling on port B, out-of-range error reporting
// and read-first responses after a fixed RD_LAT cycles.
// Optional feature macro RAM_CLEAR_EN: after reset a counter zeroes every
// word (one per cycle) while busy_o holds both grants low.
//   clk_i, rst_ni                 clock, async active-low reset
//   x_req_i/x_gnt_o               request / combinational grant (x = a, b)
//   x_we_i, x_be_i                write enable, byte enables
//   x_addr_i, x_wdata_i           byte address, write data
//   x_rvalid_o, x_rdata_o, x_err_o response, read-first data, range error
//   busy_o                        array unavailable (reset / clearing)
module ram_2p
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16384,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter string       INIT_FILE = ""
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                a_req_i,
  output logic                a_gnt_o,
  input  logic                a_we_i,
  input  logic [DATA_W/8-1:0] a_be_i,
  input  logic [31:0]         a_addr_i,
  input  logic [DATA_W-1:0]   a_wdata_i,
  output logic                a_rvalid_o,
  output logic [DATA_W-1:0]   a_rdata_o,
  output logic                a_err_o,
  input  logic                b_req_i,
  output logic                b_gnt_o,
  input  logic                b_we_i,
  input  logic [DATA_W/8-1:0] b_be_i,
  input  logic [31:0]         b_addr_i,
  input  logic [DATA_W-1:0]   b_wdata_i,
  output logic                b_rvalid_o,
  output logic [DATA_W-1:0]   b_rdata_o,
  output logic                b_err_o,
  output logic                busy_o
);

  localparam int unsigned BE_W   = RAM_BE_W(DATA_W);
  localparam int unsigned OFF_SH = $clog2(BE_W);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  ram_state_e state_q, state_d;

  ram_idx_t          a_rng_s, b_rng_s;
  logic [IDX_W-1:0]  a_idx_s, b_idx_s;
  logic              a_acc_s, b_acc_s;
  logic              a_wr_s, b_wr_s;
  logic              collide_s;
  logic [DATA_W-1:0] a_rd_s, b_rd_s;

  assign a_rng_s = ram_word_idx(a_addr_i, BASE_ADDR, OFF_SH, DEPTH);
  assign b_rng_s = ram_word_idx(b_addr_i, BASE_ADDR, OFF_SH, DEPTH);
  assign a_idx_s = a_rng_s.idx[IDX_W-1:0];
  assign b_idx_s = b_rng_s.idx[IDX_W-1:0];

  assign busy_o = (state_q != RAM_ST_READY);

  // Only two in-range writes to the same word collide; out-of-range writes
  // never touch the array so they cannot conflict.
  assign collide_s = a_req_i && a_we_i && b_req_i && b_we_i &&
                     a_rng_s.in_range && b_rng_s.in_range && (a_idx_s == b_idx_s);

  assign a_gnt_o = !busy_o;
  assign b_gnt_o = !busy_o && !collide_s;

  assign a_acc_s = a_req_i && a_gnt_o;
  assign b_acc_s = b_req_i && b_gnt_o;
  assign a_wr_s  = a_acc_s && a_we_i && a_rng_s.in_range;
  assign b_wr_s  = b_acc_s && b_we_i && b_rng_s.in_range;

  // Read-first: the word is sampled before this edge's write lands.
  assign a_rd_s = a_rng_s.in_range ? mem[a_idx_s] : '0;
  assign b_rd_s = b_rng_s.in_range ? mem[b_idx_s] : '0;

`ifdef RAM_CLEAR_EN
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_we_s;
  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);
`endif

  // Next-state logic; with clearing enabled the RESET cycle already writes
  // word 0 so the array is busy for exactly DEPTH cycles.
  always_comb begin
    state_d = state_q;
`ifdef RAM_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
    clr_we_s  = 1'b0;
`endif
    case (state_q)
      RAM_ST_RESET: begin
`ifdef RAM_CLEAR_EN
        clr_we_s  = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        state_d   = RAM_ST_CLEAR;
`else
        state_d   = RAM_ST_READY;
`endif
      end
      RAM_ST_CLEAR: begin
`ifdef RAM_CLEAR_EN
        clr_we_s = 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = RAM_ST_READY;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          state_d   = RAM_ST_CLEAR;
        end
`else
        state_d = RAM_ST_READY;
`endif
      end
      RAM_ST_READY: begin
        state_d = RAM_ST_READY;
      end
      default: begin
        state_d = RAM_ST_RESET;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RAM_ST_RESET;
`ifdef RAM_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef RAM_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // Array writes. Both ports may write in one cycle only to different words.
  always_ff @(posedge clk_i) begin
`ifdef RAM_CLEAR_EN
    if (clr_we_s) begin
      mem[clr_cnt_q] <= '0;
    end
`endif
    for (int i = 0; i < int'(BE_W); i++) begin
      if (a_wr_s && a_be_i[i]) begin
        mem[a_idx_s][8*i +: 8] <= a_wdata_i[8*i +: 8];
      end
      if (b_wr_s && b_be_i[i]) begin
        mem[b_idx_s][8*i +: 8] <= b_wdata_i[8*i +: 8];
      end
    end
  end

  ram_rsp_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_a (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (a_acc_s),
    .err_i    (!a_rng_s.in_range),
    .rdata_i  (a_rd_s),
    .rvalid_o (a_rvalid_o),
    .err_o    (a_err_o),
    .rdata_o  (a_rdata_o)
  );

  ram_rsp_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_b (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (b_acc_s),
    .err_i    (!b_rng_s.in_range),
    .rdata_i  (b_rd_s),
    .rvalid_o (b_rvalid_o),
    .err_o    (b_err_o),
    .rdata_o  (b_rdata_o)
  );

endmodule

// File: tb/tb_ram_2p.sv
// tb_ram_2p: scoreboard bench for ram_2p (DATA_W=32, DEPTH=64, RD_LAT=3,
// BASE_ADDR=0x100). Drivers push hand-computed responses into per-port
// queues; a monitor pops and compares whenever rvalid is seen.
module tb_ram_2p;

  localparam int unsigned DW   = 32;
  localparam int unsigned DEP  = 64;
  localparam int unsigned LAT  = 3;
  localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef RAM_CLEAR_EN
  localparam int READY_N = DEP;
  localparam bit CLR = 1'b1;
`else
  localparam int READY_N = 1;
  localparam bit CLR = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          a_req_i = 1'b0, b_req_i = 1'b0;
  logic          a_we_i = 1'b0, b_we_i = 1'b0;
  logic [3:0]    a_be_i = 4'h0, b_be_i = 4'h0;
  logic [31:0]   a_addr_i = 32'h0, b_addr_i = 32'h0;
  logic [31:0]   a_wdata_i = 32'h0, b_wdata_i = 32'h0;
  logic          a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_err_o, b_err_o, busy_o;
  logic [31:0]   a_rdata_o, b_rdata_o;

  ram_2p #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(LAT), .BASE_ADDR(BASE), .INIT_FILE("")) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_req_i(a_req_i), .a_gnt_o(a_gnt_o), .a_we_i(a_we_i), .a_be_i(a_be_i),
    .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_rvalid_o(a_rvalid_o),
    .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
    .b_req_i(b_req_i), .b_gnt_o(b_gnt_o), .b_we_i(b_we_i), .b_be_i(b_be_i),
    .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i), .b_rvalid_o(b_rvalid_o),
    .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic [31:0] data;
    bit          chk;
    int          cyc;
    int          tag;
  } exp_t;

  typedef struct {
    bit          req;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          gnt;
    logic        err;
    logic [31:0] data;
    bit          chk;
  } op_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;
  int   tag_cnt = 0;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic op_t idle();
    op_t o;
    o = '{default: '0};
    return o;
  endfunction

  function automatic op_t rd(input logic [31:0] addr, input logic err, input logic [31:0] data);
    op_t o;
    o = '{default: '0};
    o.req = 1'b1; o.addr = addr; o.gnt = 1'b1; o.err = err; o.data = data; o.chk = 1'b1;
    return o;
  endfunction

  function automatic op_t wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                             input logic err, input logic [31:0] old, input bit chk, input bit gnt);
    op_t o;
    o.req = 1'b1; o.we = 1'b1; o.be = be; o.addr = addr; o.wd = wd;
    o.gnt = gnt; o.err = err; o.data = old; o.chk = chk;
    return o;
  endfunction

  // One bus cycle on both ports: drive, check grants, push expected responses.
  task automatic cyc(input op_t a, input op_t b);
    exp_t e;
    @(negedge clk_i);
    a_req_i = a.req; a_we_i = a.we; a_be_i = a.be; a_addr_i = a.addr; a_wdata_i = a.wd;
    b_req_i = b.req; b_we_i = b.we; b_be_i = b.be; b_addr_i = b.addr; b_wdata_i = b.wd;
    #1;
    if (a.req) check("a_gnt", {31'h0, a_gnt_o}, {31'h0, a.gnt});
    if (b.req) check("b_gnt", {31'h0, b_gnt_o}, {31'h0, b.gnt});
    if (a.req && a_gnt_o) begin
      e = '{err: a.err, data: a.data, chk: a.chk, cyc: cyc_cnt + LAT, tag: tag_cnt};
      qa.push_back(e);
      tag_cnt++;
    end
    if (b.req && b_gnt_o) begin
      e = '{err: b.err, data: b.data, chk: b.chk, cyc: cyc_cnt + LAT, tag: tag_cnt};
      qb.push_back(e);
      tag_cnt++;
    end
  endtask

  task automatic cmp_rsp(input string name, input exp_t e, input logic err, input logic [31:0] data);
    if (err !== e.err || (e.chk && data !== e.data) || cyc_cnt != e.cyc) begin
      failures++;
      $display("FAIL %s tag=%0d got err=%b data=%h cyc=%0d exp err=%b data=%h cyc=%0d chk=%0d",
               name, e.tag, err, data, cyc_cnt, e.err, e.data, e.cyc, e.chk);
    end
  endtask

  // Response monitor.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      if (a_rvalid_o) begin
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL rsp_a unexpected response err=%b data=%h", a_err_o, a_rdata_o);
        end else begin
          e = qa.pop_front();
          cmp_rsp("rsp_a", e, a_err_o, a_rdata_o);
        end
      end
      if (b_rvalid_o) begin
        checks++;
        if (qb.size() == 0) begin
          failures++;
          $display("FAIL rsp_b unexpected response err=%b data=%h", b_err_o, b_rdata_o);
        end else begin
          e = qb.pop_front();
          cmp_rsp("rsp_b", e, b_err_o, b_rdata_o);
        end
      end
    end
  end

  task automatic drain();
    @(negedge clk_i);
    a_req_i = 1'b0; b_req_i = 1'b0;
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk_i);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain pending a=%0d b=%0d exp 0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  // Count edges after release until busy_o drops; grants must stay low.
  task automatic wait_ready();
    int n;
    n = 0;
    while (n < 200) begin
      @(posedge clk_i); #1;
      n++;
      if (!busy_o) break;
      check("gnt_busy", {30'h0, a_gnt_o, b_gnt_o}, 32'h0);
    end
    check("busy_cycles", n, READY_N);
    check("gnt_ready", {30'h0, a_gnt_o, b_gnt_o}, 32'h3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_gnt", {30'h0, a_gnt_o, b_gnt_o}, 32'h0);
    check("rst_rvalid", {30'h0, a_rvalid_o, b_rvalid_o}, 32'h0);
    check("rst_rdata", a_rdata_o | b_rdata_o, 32'h0);
    check("rst_err", {30'h0, a_err_o, b_err_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h1);
    @(negedge clk_i); rst_ni = 1'b1;
    wait_ready();

    // Known contents for words used later (old data unknown without clear).
    cyc(wr(BASE+32'h40, 4'hF, 32'h0, 1'b0, 32'h0, CLR, 1'b1),
        wr(BASE+32'h20, 4'hF, 32'h2222_2222, 1'b0, 32'h0, CLR, 1'b1));
    cyc(wr(BASE+32'h10, 4'hF, 32'h0, 1'b0, 32'h0, CLR, 1'b1),
        wr(BASE+32'hFC, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0, CLR, 1'b1));
    cyc(wr(BASE+32'h00, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0, CLR, 1'b1), idle());
    if (!CLR) cyc(wr(BASE+32'h14, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1), idle());
    cyc(rd(BASE+32'h14, 1'b0, 32'h0), idle());
    drain();

    // Byte-enabled write, read-first response, then read back.
    cyc(wr(BASE+32'h40, 4'b0101, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 1'b1), idle());
    cyc(rd(BASE+32'h40, 1'b0, 32'h00AD_00EF), idle());
    cyc(rd(BASE+32'h43, 1'b0, 32'h00AD_00EF), rd(BASE+32'hFC, 1'b0, 32'hCAFE_F00D));
    drain();

    // Same-word write collision: B stalls, then lands on top of A.
    cyc(wr(BASE+32'h10, 4'hF, 32'hAAAA_5555, 1'b0, 32'h0, 1'b1, 1'b1),
        wr(BASE+32'h10, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 1'b0));
    cyc(idle(), wr(BASE+32'h10, 4'hF, 32'h1234_5678, 1'b0, 32'hAAAA_5555, 1'b1, 1'b1));
    cyc(rd(BASE+32'h10, 1'b0, 32'h1234_5678), idle());
    drain();

    // A writes, B reads same word: B sees old data; then both read.
    cyc(wr(BASE+32'h20, 4'hF, 32'h1111_1111, 1'b0, 32'h2222_2222, 1'b1, 1'b1),
        rd(BASE+32'h20, 1'b0, 32'h2222_2222));
    cyc(rd(BASE+32'h20, 1'b0, 32'h1111_1111), rd(BASE+32'h20, 1'b0, 32'h1111_1111));
    drain();

    // Out-of-range above and below; OOR write must not alias onto word 0.
    cyc(rd(BASE+DEP*4, 1'b1, 32'h0),
        wr(BASE+DEP*4, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1'b1));
    cyc(rd(BASE-32'h4, 1'b1, 32'h0), rd(BASE+32'h00, 1'b0, 32'h0BAD_F00D));
    drain();

    // Reset with responses in flight.
    cyc(rd(BASE+32'h40, 1'b0, 32'h00AD_00EF), rd(BASE+32'h20, 1'b0, 32'h1111_1111));
    cyc(rd(BASE+32'h40, 1'b0, 32'h00AD_00EF), idle());
    @(posedge clk_i); #1;
    a_req_i = 1'b0; b_req_i = 1'b0;
    @(posedge clk_i); #1;
    check("inflight_visible", {30'h0, a_rvalid_o, b_rvalid_o}, 32'h3);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_rvalid", {30'h0, a_rvalid_o, b_rvalid_o}, 32'h0);
    check("rst_mid_rdata", a_rdata_o | b_rdata_o, 32'h0);
    qa.delete(); qb.delete();
    repeat (3) @(negedge clk_i);
    check("rst_mid_busy", {31'h0, busy_o}, 32'h1);
    rst_ni = 1'b1;
    wait_ready();
    repeat (8) @(negedge clk_i);
    cyc(rd(BASE+32'h40, 1'b0, CLR ? 32'h0 : 32'h00AD_00EF),
        rd(BASE+32'h20, 1'b0, CLR ? 32'h0 : 32'h1111_1111));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
